// File: rtl/controller_pkg.sv
// Shared definitions for the controller poller: FSM states, register field
// offsets and the legal per-pad button counts.
package controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LATCH,
    ST_SHIFT,
    ST_COMMIT
  } poll_state_t;

  localparam logic [1:0] FIELD_STATE_LO   = 2'd0;
  localparam logic [1:0] FIELD_STATE_HI   = 2'd1;
  localparam logic [1:0] FIELD_PRESSED_LO = 2'd2;
  localparam logic [1:0] FIELD_PRESSED_HI = 2'd3;

  localparam int unsigned BUTTONS_NARROW  = 8;
  localparam int unsigned BUTTONS_WIDE    = 16;
  localparam int unsigned MAX_CONTROLLERS = 4;

endpackage

// File: rtl/controller_poller_m_if.sv
// CPU register window of the controller poller.
interface controller_poller_m_if;
  logic       sel;
  logic [3:0] reg_addr;
  logic       read_strobe;
  logic [7:0] data_out;

  modport master (output sel, reg_addr, read_strobe, input data_out);
  modport slave  (input sel, reg_addr, read_strobe, output data_out);
endinterface

// File: rtl/controller_channel_m.sv
// One serial pad: shift register, committed button state and sticky
// pressed-edge bits with byte-wise clear-on-read.
module controller_channel_m
  import controller_pkg::*;
#(
  parameter int unsigned NUM_BUTTONS = 8
) (
  input  logic                   cpu_clk,
  input  logic                   rst_B,
  input  logic                   sample_en,
  input  logic                   commit,
  input  logic                   serial_in,
  input  logic                   clr_lo,
  input  logic                   clr_hi,
  output logic [NUM_BUTTONS-1:0] state,
  output logic [NUM_BUTTONS-1:0] pressed
);

  logic [NUM_BUTTONS-1:0] shift_q;
  logic [NUM_BUTTONS-1:0] clr_mask;

  always_comb begin
    clr_mask = '0;
    for (int unsigned b = 0; b < NUM_BUTTONS; b++) begin
      clr_mask[b] = (b < BUTTONS_NARROW) ? clr_lo : clr_hi;
    end
  end

  // Shifting in at the MSB end leaves the first sample in bit 0 after a full poll.
  always_ff @(posedge cpu_clk or negedge rst_B) begin
    if (!rst_B) begin
      shift_q <= '0;
      state   <= '0;
      pressed <= '0;
    end else begin
      if (sample_en) begin
        shift_q <= {serial_in, shift_q[NUM_BUTTONS-1:1]};
      end
      if (commit) begin
        state   <= shift_q;
        pressed <= (pressed & ~clr_mask) | (shift_q & ~state);
      end else begin
        pressed <= pressed & ~clr_mask;
      end
    end
  end

endmodule

// File: rtl/controller_poller_m.sv
// Polls up to four serial pads on request, keeps per-pad state and pressed
// bits, and exposes them through a small clear-on-read register window.
module controller_poller_m
  import controller_pkg::*;
#(
  parameter int unsigned NUM_CONTROLLERS = 2,
  parameter int unsigned NUM_BUTTONS     = 8
) (
  input  logic                       cpu_clk,
  input  logic                       rst_B,
  input  logic                       controller_clk_in_enable,
  input  logic                       start_fetch,
  output logic                       controller_clk_out_enable,
  output logic                       controller_latch,
  input  logic [NUM_CONTROLLERS-1:0] data_in_B,
  controller_poller_m_if.slave       cpu,
  output logic                       press_irq,
  output logic                       busy
);

  localparam int unsigned CNT_W = $clog2(NUM_BUTTONS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NUM_BUTTONS - 1);

  poll_state_t      state_q, state_d;
  logic [CNT_W-1:0] bit_cnt;
  logic             sample_en;
  logic             commit;

  always_ff @(posedge cpu_clk or negedge rst_B) begin
    if (!rst_B) begin
      state_q <= ST_IDLE;
      bit_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (sample_en) begin
        bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_d                   = state_q;
    controller_latch          = 1'b0;
    controller_clk_out_enable = 1'b0;
    sample_en                 = 1'b0;
    commit                    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_fetch) state_d = ST_LATCH;
      end
      ST_LATCH: begin
        controller_latch = 1'b1;
        if (controller_clk_in_enable) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        controller_clk_out_enable = controller_clk_in_enable;
        sample_en                 = controller_clk_in_enable;
        if (controller_clk_in_enable && bit_cnt == LAST_BIT) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        commit  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q != ST_IDLE);

  logic [1:0] pad_idx;
  logic [1:0] field;
  logic       pad_valid;
  logic       rd_clr;

  assign pad_idx   = cpu.reg_addr[3:2];
  assign field     = cpu.reg_addr[1:0];
  assign pad_valid = (32'(pad_idx) < NUM_CONTROLLERS);
  assign rd_clr    = cpu.sel & cpu.read_strobe & pad_valid;

  // Unpopulated pad slots read as zero, so the mux never needs a range check on the index.
  logic [15:0] state_w   [MAX_CONTROLLERS];
  logic [15:0] pressed_w [MAX_CONTROLLERS];

  for (genvar g = 0; g < MAX_CONTROLLERS; g++) begin : g_pad
    if (g < NUM_CONTROLLERS) begin : g_used
      logic [NUM_BUTTONS-1:0] ch_state;
      logic [NUM_BUTTONS-1:0] ch_pressed;

      controller_channel_m #(.NUM_BUTTONS(NUM_BUTTONS)) u_channel (
        .cpu_clk   (cpu_clk),
        .rst_B     (rst_B),
        .sample_en (sample_en),
        .commit    (commit),
        .serial_in (~data_in_B[g]),
        .clr_lo    (rd_clr && pad_idx == 2'(g) && field == FIELD_PRESSED_LO),
        .clr_hi    (rd_clr && pad_idx == 2'(g) && field == FIELD_PRESSED_HI),
        .state     (ch_state),
        .pressed   (ch_pressed)
      );

      assign state_w[g]   = 16'(ch_state);
      assign pressed_w[g] = 16'(ch_pressed);
    end else begin : g_unused
      assign state_w[g]   = '0;
      assign pressed_w[g] = '0;
    end
  end

  always_comb begin
    cpu.data_out = '0;
    if (cpu.sel && pad_valid) begin
      unique case (field)
        FIELD_STATE_LO:   cpu.data_out = state_w[pad_idx][7:0];
        FIELD_STATE_HI:   cpu.data_out = state_w[pad_idx][15:8];
        FIELD_PRESSED_LO: cpu.data_out = pressed_w[pad_idx][7:0];
        FIELD_PRESSED_HI: cpu.data_out = pressed_w[pad_idx][15:8];
        default:          cpu.data_out = '0;
      endcase
    end
  end

  logic any_pressed;

  always_comb begin
    any_pressed = 1'b0;
    for (int unsigned i = 0; i < MAX_CONTROLLERS; i++) begin
      any_pressed = any_pressed | (|pressed_w[i]);
    end
  end

  always_ff @(posedge cpu_clk or negedge rst_B) begin
    if (!rst_B) press_irq <= 1'b0;
    else        press_irq <= any_pressed;
  end

endmodule

// File: tb/tb_controller_poller_m.sv
// Bench for controller_poller_m: default (2 pads x 8) and wide (3 pads x 16)
// instances against a per-pad state/pressed reference model.
module tb_controller_poller_m;

  logic cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  logic       rst_B;
  logic       tick, start_fetch, clk_out_en, latch, press_irq, busy;
  logic [1:0] data_in_B;
  controller_poller_m_if cpu_bus ();

  controller_poller_m dut (
    .cpu_clk                   (cpu_clk),
    .rst_B                     (rst_B),
    .controller_clk_in_enable  (tick),
    .start_fetch               (start_fetch),
    .controller_clk_out_enable (clk_out_en),
    .controller_latch          (latch),
    .data_in_B                 (data_in_B),
    .cpu                       (cpu_bus),
    .press_irq                 (press_irq),
    .busy                      (busy)
  );

  logic       w_tick, w_start, w_clk_out_en, w_latch, w_irq, w_busy;
  logic [2:0] w_data_in_B;
  controller_poller_m_if w_bus ();

  controller_poller_m #(.NUM_CONTROLLERS(3), .NUM_BUTTONS(16)) dut_w (
    .cpu_clk                   (cpu_clk),
    .rst_B                     (rst_B),
    .controller_clk_in_enable  (w_tick),
    .start_fetch               (w_start),
    .controller_clk_out_enable (w_clk_out_en),
    .controller_latch          (w_latch),
    .data_in_B                 (w_data_in_B),
    .cpu                       (w_bus),
    .press_irq                 (w_irq),
    .busy                      (w_busy)
  );

  int checks = 0;
  int passes = 0;

  // Reference model: what each pad last reported and which buttons went down since last read.
  logic [7:0]  m_state   [2];
  logic [7:0]  m_pressed [2];
  logic [15:0] mw_state   [3];
  logic [15:0] mw_pressed [3];

  task automatic cyc();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin m_state[p] = '0; m_pressed[p] = '0; end
    for (int p = 0; p < 3; p++) begin mw_state[p] = '0; mw_pressed[p] = '0; end
  endtask

  task automatic model_commit(input logic [7:0] v0, input logic [7:0] v1);
    m_pressed[0] = m_pressed[0] | (v0 & ~m_state[0]);
    m_pressed[1] = m_pressed[1] | (v1 & ~m_state[1]);
    m_state[0] = v0;
    m_state[1] = v1;
  endtask

  function automatic logic [7:0] exp_read(input logic [3:0] a, input logic s);
    if (!s || a[3:2] > 2'd1) return 8'h00;
    case (a[1:0])
      2'd0:    return m_state[a[2]];
      2'd2:    return m_pressed[a[2]];
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_read_clear(input logic [3:0] a, input logic s, input logic stb);
    if (s && stb && a[3:2] <= 2'd1 && a[1:0] == 2'd2) m_pressed[a[2]] = 8'h00;
  endtask

  function automatic logic [7:0] exp_read_w(input logic [3:0] a);
    int p;
    p = int'(a[3:2]);
    if (p >= 3) return 8'h00;
    case (a[1:0])
      2'd0:    return mw_state[p][7:0];
      2'd1:    return mw_state[p][15:8];
      2'd2:    return mw_pressed[p][7:0];
      default: return mw_pressed[p][15:8];
    endcase
  endfunction

  function automatic logic exp_irq();
    return (m_pressed[0] != 0) || (m_pressed[1] != 0);
  endfunction

  // Leaves the default instance in its commit cycle, just after the last shift tick.
  task automatic poll_to_commit(input logic [7:0] v0, input logic [7:0] v1);
    start_fetch = 1'b1; cyc(); start_fetch = 1'b0;
    repeat ($urandom_range(0, 2)) cyc();
    tick = 1'b1; cyc(); tick = 1'b0;
    for (int k = 0; k < 8; k++) begin
      repeat ($urandom_range(0, 2)) cyc();
      data_in_B = ~{v1[k], v0[k]};
      tick = 1'b1; cyc(); tick = 1'b0;
    end
    data_in_B = '1;
  endtask

  task automatic do_read(input logic [3:0] a, input logic s, input logic stb, output logic [7:0] got);
    cpu_bus.sel = s; cpu_bus.reg_addr = a; cpu_bus.read_strobe = stb;
    #1 got = cpu_bus.data_out;
    cyc();
    cpu_bus.sel = 1'b0; cpu_bus.read_strobe = 1'b0;
  endtask

  task automatic w_poll(input logic [15:0] v0, input logic [15:0] v1, input logic [15:0] v2);
    w_start = 1'b1; cyc(); w_start = 1'b0;
    repeat ($urandom_range(0, 2)) cyc();
    w_tick = 1'b1; cyc(); w_tick = 1'b0;
    for (int k = 0; k < 16; k++) begin
      repeat ($urandom_range(0, 1)) cyc();
      w_data_in_B = ~{v2[k], v1[k], v0[k]};
      w_tick = 1'b1; cyc(); w_tick = 1'b0;
    end
    w_data_in_B = '1;
    cyc();
    mw_pressed[0] = mw_pressed[0] | (v0 & ~mw_state[0]);
    mw_pressed[1] = mw_pressed[1] | (v1 & ~mw_state[1]);
    mw_pressed[2] = mw_pressed[2] | (v2 & ~mw_state[2]);
    mw_state[0] = v0; mw_state[1] = v1; mw_state[2] = v2;
  endtask

  task automatic w_read(input logic [3:0] a, input logic stb, output logic [7:0] got);
    w_bus.sel = 1'b1; w_bus.reg_addr = a; w_bus.read_strobe = stb;
    #1 got = w_bus.data_out;
    cyc();
    w_bus.sel = 1'b0; w_bus.read_strobe = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] got;
    rst_B = 1'b0;
    repeat (3) cyc();
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%0b exp=0", busy); else passes++;
    checks++; if (latch !== 1'b0) $display("FAIL reset_latch got=%0b exp=0", latch); else passes++;
    checks++; if (clk_out_en !== 1'b0) $display("FAIL reset_clk_out got=%0b exp=0", clk_out_en); else passes++;
    checks++; if (press_irq !== 1'b0) $display("FAIL reset_irq got=%0b exp=0", press_irq); else passes++;
    checks++; if (w_busy !== 1'b0) $display("FAIL reset_w_busy got=%0b exp=0", w_busy); else passes++;
    rst_B = 1'b1;
    cyc();
    do_read(4'h0, 1'b1, 1'b0, got);
    checks++; if (got !== 8'h00) $display("FAIL reset_state0 got=%h exp=00", got); else passes++;
    model_reset();
  endtask

  task automatic test_poll_sequence();
    logic [7:0] v0, v1, got;
    v0 = 8'hB1;
    v1 = 8'($urandom);
    start_fetch = 1'b1; cyc(); start_fetch = 1'b0;
    checks++; if (latch !== 1'b1 || busy !== 1'b1 || clk_out_en !== 1'b0)
      $display("FAIL latch_entry latch=%0b busy=%0b clk_out=%0b exp=1,1,0", latch, busy, clk_out_en); else passes++;
    tick = 1'b1;
    #1;
    checks++; if (clk_out_en !== 1'b0) $display("FAIL latch_no_clk got=%0b exp=0", clk_out_en); else passes++;
    cyc(); tick = 1'b0;
    #1;
    checks++; if (latch !== 1'b0 || clk_out_en !== 1'b0)
      $display("FAIL shift_idle latch=%0b clk_out=%0b exp=0,0", latch, clk_out_en); else passes++;
    for (int k = 0; k < 8; k++) begin
      data_in_B = ~{v1[k], v0[k]};
      tick = 1'b1;
      start_fetch = (k == 3);
      #1;
      checks++; if (clk_out_en !== 1'b1) $display("FAIL shift_clk_out tick=%0d got=%0b exp=1", k, clk_out_en); else passes++;
      cyc(); tick = 1'b0; start_fetch = 1'b0;
      if (k == 6) begin
        checks++; if (busy !== 1'b1) $display("FAIL seven_ticks_busy got=%0b exp=1", busy); else passes++;
      end
      repeat ($urandom_range(0, 2)) cyc();
    end
    data_in_B = '1;
    cyc(); cyc();
    checks++; if (busy !== 1'b0) $display("FAIL no_queued_start got=%0b exp=0", busy); else passes++;
    model_commit(v0, v1);
    do_read(4'h0, 1'b1, 1'b0, got);
    checks++; if (got !== 8'hB1) $display("FAIL state0 got=%h exp=b1", got); else passes++;
    do_read(4'h2, 1'b1, 1'b0, got);
    checks++; if (got !== 8'hB1) $display("FAIL pressed0 got=%h exp=b1", got); else passes++;
    do_read(4'h4, 1'b1, 1'b0, got);
    checks++; if (got !== exp_read(4'h4, 1'b1)) $display("FAIL state1 got=%h exp=%h", got, exp_read(4'h4, 1'b1)); else passes++;
    checks++; if (press_irq !== 1'b1) $display("FAIL irq_after_poll got=%0b exp=1", press_irq); else passes++;
  endtask

  task automatic test_clear_on_read();
    logic [7:0] got;
    do_read(4'h2, 1'b1, 1'b1, got);
    checks++; if (got !== 8'hB1) $display("FAIL clr_first_read got=%h exp=b1", got); else passes++;
    model_read_clear(4'h2, 1'b1, 1'b1);
    do_read(4'h2, 1'b1, 1'b1, got);
    checks++; if (got !== 8'h00) $display("FAIL clr_second_read got=%h exp=00", got); else passes++;
    do_read(4'h6, 1'b1, 1'b1, got);
    checks++; if (got !== m_pressed[1]) $display("FAIL clr_pad1 got=%h exp=%h", got, m_pressed[1]); else passes++;
    model_read_clear(4'h6, 1'b1, 1'b1);
    do_read(4'h0, 1'b1, 1'b1, got);
    checks++; if (got !== 8'hB1) $display("FAIL state_survives_read got=%h exp=b1", got); else passes++;
    do_read(4'h3, 1'b1, 1'b0, got);
    checks++; if (got !== 8'h00) $display("FAIL narrow_hi_field got=%h exp=00", got); else passes++;
    cyc();
    checks++; if (press_irq !== 1'b0) $display("FAIL irq_after_clear got=%0b exp=0", press_irq); else passes++;
  endtask

  task automatic test_edge_detect();
    logic [7:0] got;
    poll_to_commit(8'hB3, m_state[1]); cyc();
    model_commit(8'hB3, m_state[1]);
    do_read(4'h2, 1'b1, 1'b0, got);
    checks++; if (got !== 8'h02) $display("FAIL held_bits_pressed got=%h exp=02", got); else passes++;
    do_read(4'h6, 1'b1, 1'b0, got);
    checks++; if (got !== 8'h00) $display("FAIL unchanged_pad1 got=%h exp=00", got); else passes++;
    checks++; if (press_irq !== 1'b1) $display("FAIL irq_new_edge got=%0b exp=1", press_irq); else passes++;
  endtask

  task automatic test_commit_clear();
    logic [7:0] got, exp_old;
    poll_to_commit(8'hB7, m_state[1]);
    exp_old = m_pressed[0];
    do_read(4'h2, 1'b1, 1'b1, got);
    checks++; if (got !== exp_old) $display("FAIL commit_read_old got=%h exp=%h", got, exp_old); else passes++;
    model_read_clear(4'h2, 1'b1, 1'b1);
    model_commit(8'hB7, m_state[1]);
    do_read(4'h2, 1'b1, 1'b0, got);
    checks++; if (got !== 8'h04) $display("FAIL set_beats_clear got=%h exp=04", got); else passes++;
  endtask

  task automatic test_window_guards();
    logic [7:0] got;
    do_read(4'h0, 1'b0, 1'b1, got);
    checks++; if (got !== 8'h00) $display("FAIL sel_low_read got=%h exp=00", got); else passes++;
    do_read(4'h2, 1'b0, 1'b1, got);
    do_read(4'hA, 1'b1, 1'b1, got);
    checks++; if (got !== 8'h00) $display("FAIL absent_pad2 got=%h exp=00", got); else passes++;
    do_read(4'hE, 1'b1, 1'b1, got);
    do_read(4'h2, 1'b1, 1'b0, got);
    checks++; if (got !== 8'h04) $display("FAIL no_side_effect got=%h exp=04", got); else passes++;
  endtask

  task automatic test_random();
    logic [7:0] v0, v1, got, exp;
    logic [3:0] a;
    logic       s, stb;
    for (int it = 0; it < 8; it++) begin
      v0 = 8'($urandom);
      v1 = 8'($urandom);
      poll_to_commit(v0, v1); cyc();
      model_commit(v0, v1);
      for (int r = 0; r < 6; r++) begin
        a = 4'($urandom);
        s = ($urandom_range(0, 3) != 0);
        stb = 1'($urandom);
        exp = exp_read(a, s);
        do_read(a, s, stb, got);
        checks++; if (got !== exp)
          $display("FAIL rand_read it=%0d addr=%h sel=%0b got=%h exp=%h", it, a, s, got, exp); else passes++;
        model_read_clear(a, s, stb);
      end
      cyc();
      checks++; if (press_irq !== exp_irq())
        $display("FAIL rand_irq it=%0d got=%0b exp=%0b", it, press_irq, exp_irq()); else passes++;
    end
  endtask

  task automatic test_reset_midshift();
    logic [7:0] v0, got;
    poll_to_commit(8'h00, 8'h00); cyc(); model_commit(8'h00, 8'h00);
    poll_to_commit(8'h5A, 8'hC3); cyc(); model_commit(8'h5A, 8'hC3);
    cyc();
    checks++; if (press_irq !== 1'b1) $display("FAIL pre_reset_irq got=%0b exp=1", press_irq); else passes++;
    start_fetch = 1'b1; cyc(); start_fetch = 1'b0;
    tick = 1'b1; cyc(); tick = 1'b0;
    for (int k = 0; k < 3; k++) begin
      data_in_B = 2'b00;
      tick = 1'b1; cyc(); tick = 1'b0;
    end
    start_fetch = 1'b1; cyc(); start_fetch = 1'b0;
    rst_B = 1'b0; tick = 1'b1;
    cpu_bus.sel = 1'b1; cpu_bus.reg_addr = 4'h2;
    #1;
    checks++; if (busy !== 1'b0 || latch !== 1'b0 || clk_out_en !== 1'b0 || press_irq !== 1'b0)
      $display("FAIL midshift_reset busy=%0b latch=%0b clk_out=%0b irq=%0b exp=0", busy, latch, clk_out_en, press_irq); else passes++;
    checks++; if (cpu_bus.data_out !== 8'h00) $display("FAIL reset_pressed got=%h exp=00", cpu_bus.data_out); else passes++;
    cyc();
    rst_B = 1'b1; tick = 1'b0; cpu_bus.sel = 1'b0; data_in_B = '1;
    model_reset();
    cyc(); cyc();
    checks++; if (busy !== 1'b0) $display("FAIL start_not_queued got=%0b exp=0", busy); else passes++;
    v0 = 8'($urandom) | 8'h80;
    start_fetch = 1'b1; cyc(); start_fetch = 1'b0;
    tick = 1'b1; cyc(); tick = 1'b0;
    for (int k = 0; k < 8; k++) begin
      data_in_B = ~{1'b0, v0[k]};
      tick = 1'b1; cyc(); tick = 1'b0;
      if (k == 6) begin
        checks++; if (busy !== 1'b1) $display("FAIL post_reset_seven got=%0b exp=1", busy); else passes++;
      end
    end
    data_in_B = '1;
    cyc();
    model_commit(v0, 8'h00);
    do_read(4'h0, 1'b1, 1'b0, got);
    checks++; if (got !== v0) $display("FAIL post_reset_state got=%h exp=%h", got, v0); else passes++;
    do_read(4'h2, 1'b1, 1'b0, got);
    checks++; if (got !== v0) $display("FAIL post_reset_pressed got=%h exp=%h", got, v0); else passes++;
  endtask

  task automatic test_wide();
    logic [7:0] got, exp;
    logic [3:0] a;
    w_poll(16'($urandom), 16'($urandom), 16'hA55A);
    w_read(4'h8, 1'b0, got);
    checks++; if (got !== 8'h5A) $display("FAIL wide_state_lo got=%h exp=5a", got); else passes++;
    w_read(4'h9, 1'b0, got);
    checks++; if (got !== 8'hA5) $display("FAIL wide_state_hi got=%h exp=a5", got); else passes++;
    w_read(4'hC, 1'b1, got);
    checks++; if (got !== 8'h00) $display("FAIL wide_absent_pad got=%h exp=00", got); else passes++;
    w_read(4'hB, 1'b1, got);
    checks++; if (got !== 8'hA5) $display("FAIL wide_clr_hi got=%h exp=a5", got); else passes++;
    mw_pressed[2][15:8] = 8'h00;
    w_read(4'hB, 1'b0, got);
    checks++; if (got !== 8'h00) $display("FAIL wide_hi_cleared got=%h exp=00", got); else passes++;
    w_read(4'hA, 1'b0, got);
    checks++; if (got !== 8'h5A) $display("FAIL wide_lo_kept got=%h exp=5a", got); else passes++;
    w_poll(16'($urandom), 16'($urandom), 16'($urandom));
    for (int i = 0; i < 12; i++) begin
      a = 4'(i);
      exp = exp_read_w(a);
      w_read(a, 1'b0, got);
      checks++; if (got !== exp) $display("FAIL wide_field addr=%h got=%h exp=%h", a, got, exp); else passes++;
    end
    for (int p = 0; p < 3; p++) begin
      w_read(4'(p * 4 + 2), 1'b1, got);
      w_read(4'(p * 4 + 3), 1'b1, got);
      mw_pressed[p] = '0;
    end
    cyc();
    checks++; if (w_irq !== 1'b0) $display("FAIL wide_irq_cleared got=%0b exp=0", w_irq); else passes++;
  endtask

  initial begin
    tick = 1'b0; start_fetch = 1'b0; data_in_B = '1;
    w_tick = 1'b0; w_start = 1'b0; w_data_in_B = '1;
    cpu_bus.sel = 1'b0; cpu_bus.reg_addr = '0; cpu_bus.read_strobe = 1'b0;
    w_bus.sel = 1'b0; w_bus.reg_addr = '0; w_bus.read_strobe = 1'b0;
    test_reset();
    test_poll_sequence();
    test_clear_on_read();
    test_edge_detect();
    test_commit_clear();
    test_window_guards();
    test_random();
    test_reset_midshift();
    test_wide();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
